// File: rtl/e_pkg.sv
// Shared defaults and types for the e select-chain serializer.
package e_pkg;

   localparam int unsigned CELLS_N_DEF = 8;
   localparam int unsigned BEAT_W_DEF  = 4;
   localparam int unsigned IDX_W_DEF   = $clog2(CELLS_N_DEF);

   typedef logic [IDX_W_DEF-1:0]  idx_t;
   typedef logic [BEAT_W_DEF-1:0] beat_t;

endpackage

// File: rtl/e_lsb_encoder.sv
// Lowest-set-bit encoder: index, isolated one-hot bit and single-bit flag of a mask.
module e_lsb_encoder
   import e_pkg::*;
#(
   parameter int unsigned CELLS_N = CELLS_N_DEF
) (
   input  logic [CELLS_N-1:0]         mask_i,
   output logic [$clog2(CELLS_N)-1:0] idx_o,
   output logic [CELLS_N-1:0]         onehot_o,
   output logic                       single_o
);

   localparam int unsigned IDX_W = $clog2(CELLS_N);

   // Scan from the top so the lowest set bit wins.
   always_comb begin
      idx_o = '0;
      for (int i = CELLS_N - 1; i >= 0; i--) begin
         if (mask_i[i]) idx_o = IDX_W'(i);
      end
   end

   assign onehot_o = mask_i & (~mask_i + CELLS_N'(1));
   assign single_o = (|mask_i) & ~(|(mask_i & (mask_i - CELLS_N'(1))));

endmodule

// File: rtl/e_select_serializer.sv
// Turns per-beat select vectors into a ready/valid stream of set-bit indices, lowest first.
module e_select_serializer
   import e_pkg::*;
#(
   parameter int unsigned CELLS_N = CELLS_N_DEF,
   parameter int unsigned BEAT_W  = BEAT_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_vld_i,
   input  logic [CELLS_N-1:0]         in_sel_i,
   output logic                       in_rdy_o,
   output logic                       out_vld_o,
   output logic [$clog2(CELLS_N)-1:0] out_idx_o,
   output logic                       out_last_o,
   output logic [BEAT_W-1:0]          out_beat_o,
   input  logic                       out_rdy_i
);

   localparam int unsigned IDX_W = $clog2(CELLS_N);

   logic [CELLS_N-1:0] mask_q, mask_d;
   logic [BEAT_W-1:0]  beat_q, beat_d;
   logic [BEAT_W-1:0]  tag_q, tag_d;
   logic [CELLS_N-1:0] lsb_onehot;
   logic [IDX_W-1:0]   lsb_idx;
   logic               lsb_single;
   logic               out_fire;
   logic               in_fire;

   e_lsb_encoder #(.CELLS_N(CELLS_N)) u_lsb_encoder (
      .mask_i   (mask_q),
      .idx_o    (lsb_idx),
      .onehot_o (lsb_onehot),
      .single_o (lsb_single)
   );

   // DRAIN is simply a nonzero pending mask.
   assign out_vld_o  = |mask_q;
   assign out_idx_o  = lsb_idx;
   assign out_last_o = lsb_single;
   assign out_beat_o = tag_q;
   assign in_rdy_o   = ~rst & (~out_vld_o | (out_rdy_i & lsb_single));

   assign out_fire = out_vld_o & out_rdy_i;
   assign in_fire  = in_vld_i & in_rdy_o;

   // A new beat overrides the mask, which lets it follow the last index with no bubble.
   always_comb begin
      mask_d = mask_q;
      beat_d = beat_q;
      tag_d  = tag_q;
      if (out_fire) mask_d = mask_q & ~lsb_onehot;
      if (in_fire) begin
         mask_d = in_sel_i;
         beat_d = beat_q + BEAT_W'(1);
         if (|in_sel_i) tag_d = beat_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q <= '0;
         beat_q <= '0;
         tag_q  <= '0;
      end else begin
         mask_q <= mask_d;
         beat_q <= beat_d;
         tag_q  <= tag_d;
      end
   end

endmodule
